// File: rtl/oam_dma_engine.sv
// OAM DMA engine: stalls the CPU, copies P_count bytes from page I_page to the
// fixed register P_dest through a single shared memory port, one read + one write per byte.
module oam_dma_engine #(
    parameter int          P_count = 256,
    parameter logic [15:0] P_dest  = 16'h2004
) (
    input  logic        I_clock,
    input  logic        I_reset_n,
    input  logic        I_start,
    input  logic [7:0]  I_page,
    input  logic        I_odd,
    output logic        O_busy,
    output logic        O_halt,
    output logic        O_done,
    output logic        G_cs,
    output logic        O_rdwr,
    output logic [15:0] O_addr,
    output logic [7:0]  O_wr_data,
    input  logic [7:0]  I_rd_data
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HALT  = 3'd1;
    localparam logic [2:0] S_ALIGN = 3'd2;
    localparam logic [2:0] S_READ  = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [7:0] LAST_IDX = 8'(P_count - 1);

    logic [2:0] state_q, state_d;
    logic [7:0] page_q,  page_d;
    logic [7:0] index_q, index_d;

    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        index_d = index_q;
        case (state_q)
            S_IDLE: begin
                if (I_start) begin
                    page_d  = I_page;
                    index_d = 8'h00;
                    state_d = S_HALT;
                end
            end
            S_HALT:  state_d = I_odd ? S_ALIGN : S_READ;
            S_ALIGN: state_d = S_READ;
            S_READ:  state_d = S_WRITE;
            S_WRITE: begin
                if (index_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    // Index wraps within 8 bits; the page byte is never touched.
                    index_d = index_q + 8'd1;
                    state_d = S_READ;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge I_clock or negedge I_reset_n) begin
        if (!I_reset_n) begin
            state_q <= S_IDLE;
            page_q  <= 8'h00;
            index_q <= 8'h00;
        end else begin
            state_q <= state_d;
            page_q  <= page_d;
            index_q <= index_d;
        end
    end

    // Outputs decode the state register so reset takes effect without waiting for a clock.
    always_comb begin
        O_busy    = (state_q != S_IDLE);
        O_halt    = 1'b0;
        O_done    = 1'b0;
        G_cs      = 1'b0;
        O_rdwr    = 1'b1;
        O_addr    = 16'h0000;
        O_wr_data = 8'h00;
        case (state_q)
            S_HALT, S_ALIGN: O_halt = 1'b1;
            S_READ: begin
                O_halt = 1'b1;
                G_cs   = 1'b1;
                O_addr = {page_q, index_q};
            end
            S_WRITE: begin
                O_halt    = 1'b1;
                G_cs      = 1'b1;
                O_rdwr    = 1'b0;
                O_addr    = P_dest;
                O_wr_data = I_rd_data;
            end
            S_DONE:  O_done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_oam_dma_engine.sv
// Bench for oam_dma_engine: a default instance and a P_count=4 instance share one
// memory model; each transfer is checked cycle by cycle against an expected bus trace.
module tb_oam_dma_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start, odd, sel;
    logic [7:0] page, rd_data;

    logic        busy0, halt0, done0, cs0, rdwr0;
    logic [15:0] addr0;
    logic [7:0]  wd0;
    logic        busy1, halt1, done1, cs1, rdwr1;
    logic [15:0] addr1;
    logic [7:0]  wd1;

    oam_dma_engine dut0 (
        .I_clock(clk), .I_reset_n(rst_n), .I_start(start & ~sel), .I_page(page), .I_odd(odd),
        .O_busy(busy0), .O_halt(halt0), .O_done(done0), .G_cs(cs0), .O_rdwr(rdwr0),
        .O_addr(addr0), .O_wr_data(wd0), .I_rd_data(rd_data)
    );

    oam_dma_engine #(.P_count(4), .P_dest(16'h2004)) dut1 (
        .I_clock(clk), .I_reset_n(rst_n), .I_start(start & sel), .I_page(page), .I_odd(odd),
        .O_busy(busy1), .O_halt(halt1), .O_done(done1), .G_cs(cs1), .O_rdwr(rdwr1),
        .O_addr(addr1), .O_wr_data(wd1), .I_rd_data(rd_data)
    );

    logic        o_busy, o_halt, o_done, o_cs, o_rdwr;
    logic [15:0] o_addr;
    logic [7:0]  o_wd;
    assign o_busy = sel ? busy1 : busy0;
    assign o_halt = sel ? halt1 : halt0;
    assign o_done = sel ? done1 : done0;
    assign o_cs   = sel ? cs1   : cs0;
    assign o_rdwr = sel ? rdwr1 : rdwr0;
    assign o_addr = sel ? addr1 : addr0;
    assign o_wd   = sel ? wd1   : wd0;

    logic [7:0] mem [0:65535];

    // Memory: read data appears the cycle after a read cycle.
    always @(posedge clk) begin
        if (o_cs && o_rdwr) rd_data <= mem[o_addr];
    end

    int nvec = 0;
    int nmis = 0;

    function automatic logic [28:0] pk(input logic b, input logic h, input logic d, input logic c,
                                       input logic rw, input logic [15:0] a, input logic [7:0] w);
        return {b, h, d, c, rw, a, w};
    endfunction

    logic [28:0] obs;
    assign obs = pk(o_busy, o_halt, o_done, o_cs, o_rdwr, o_addr, o_wd);

    localparam logic [28:0] IDLE_V = 29'({1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 8'h00});

    task automatic check(input string tag, input logic [28:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        nvec++;
        assert (got === exp) else begin
            nmis++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // One transfer: expected trace is HALT, optional ALIGN, cnt read/write pairs,
    // DONE, then two idle cycles. inject pulses start at read index 10 and in DONE.
    // abort_idx >= 0 asserts reset inside the WRITE of that index.
    task automatic xfer(input logic [7:0] pg, input logic od, input int cnt,
                        input bit inject, input int abort_idx);
        logic [28:0] q[$];
        int inj_k = -1, done_k, abort_k = -1, halts = 0, dones = 0;
        logic [15:0] src;
        q.push_back(pk(1, 1, 0, 0, 1, 16'h0, 8'h0));
        if (od) q.push_back(pk(1, 1, 0, 0, 1, 16'h0, 8'h0));
        for (int i = 0; i < cnt; i++) begin
            src = {pg, 8'(i)};
            if (i == 10) inj_k = q.size();
            q.push_back(pk(1, 1, 0, 1, 1, src, 8'h0));
            q.push_back(pk(1, 1, 0, 1, 0, 16'h2004, mem[src]));
            if (i == abort_idx) abort_k = q.size() - 1;
        end
        done_k = q.size();
        q.push_back(pk(1, 0, 1, 0, 1, 16'h0, 8'h0));
        q.push_back(IDLE_V);
        q.push_back(IDLE_V);

        start = 1'b1; page = pg; odd = od;
        @(negedge clk);
        check("pre_start_idle", IDLE_V);
        @(posedge clk); #1;
        page = 8'($urandom);
        for (int k = 0; k < q.size(); k++) begin
            start = inject && (k == inj_k || k == done_k);
            odd   = (k == 0) ? od : 1'($urandom_range(0, 1));
            @(negedge clk);
            check($sformatf("pg%02h odd%0d cyc%0d", pg, od, k), q[k]);
            if (o_halt) halts++;
            if (o_done) dones++;
            if (k == abort_k) begin
                #1 rst_n = 1'b0;
                #1 check("async_reset_mid_write", IDLE_V);
                repeat (2) begin
                    @(negedge clk);
                    check("held_in_reset", IDLE_V);
                end
                @(posedge clk); #1 rst_n = 1'b1;
                start = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        check_int($sformatf("halt_cycles pg%02h odd%0d", pg, od), halts, 1 + int'(od) + 2 * cnt);
        check_int($sformatf("done_pulses pg%02h odd%0d", pg, od), dones, 1);
    endtask

    initial begin
        rst_n = 1'b1; start = 1'b0; page = 8'h00; odd = 1'b0; sel = 1'b0;
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'h5A;
        #2 rst_n = 1'b0;
        #1 check("in_reset", IDLE_V);
        @(negedge clk);
        check("in_reset_clocked", IDLE_V);
        @(posedge clk); #1 rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check($sformatf("post_reset_idle%0d", c), IDLE_V);
        end
        @(posedge clk); #1;

        xfer(8'h02, 1'b0, 256, 1'b0, -1);
        xfer(8'h02, 1'b1, 256, 1'b0, -1);
        xfer(8'h02, 1'b0, 256, 1'b1, -1);
        xfer(8'h02, 1'b0, 256, 1'b0, 100);
        xfer(8'h03, 1'b0, 256, 1'b0, -1);
        for (int r = 0; r < 2; r++) xfer(8'($urandom), 1'($urandom_range(0, 1)), 256, 1'b0, -1);

        sel = 1'b1;
        xfer(8'hAB, 1'b0, 4, 1'b0, -1);
        for (int r = 0; r < 4; r++) xfer(8'($urandom), 1'($urandom_range(0, 1)), 4, 1'b0, -1);
        xfer(8'hFF, 1'b1, 4, 1'b0, 2);
        xfer(8'h10, 1'b0, 4, 1'b0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/oam_dma_engine.md
OAM_DMA_ENGINE -- requirements
Module: oam_dma_engine

Interface
REQ-001 SHALL have parameter P_count, default 256, meaning bytes copied per transfer (legal 1..256).
REQ-002 SHALL have parameter P_dest, default 16'h2004, meaning the fixed destination address written for every byte.
REQ-003 SHALL have port I_clock  input  1  the single clock; all state changes on rising edge.
REQ-004 SHALL have port I_reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port I_start  input  1  transfer request, sampled only in IDLE.
REQ-006 SHALL have port I_page  input  8  source page (high address byte), latched on accepted start.
REQ-007 SHALL have port I_odd  input  1  high when the current bus cycle is odd, sampled in HALT.
REQ-008 SHALL have port O_busy  output  1  high in every state except IDLE.
REQ-009 SHALL have port O_halt  output  1  CPU stall request.
REQ-010 SHALL have port O_done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port G_cs  output  1  memory-port chip select.
REQ-012 SHALL have port O_rdwr  output  1  1 = read, 0 = write.
REQ-013 SHALL have port O_addr  output  16  memory-port address.
REQ-014 SHALL have port O_wr_data  output  8  write data.
REQ-015 SHALL have port I_rd_data  input  8  read data; valid the cycle after a read cycle while G_cs stays high.

Function
REQ-016 SHALL implement states IDLE, HALT, ALIGN, READ, WRITE, DONE.
REQ-017 IDLE: I_start=1 at an edge SHALL latch I_page, clear the 8-bit index, and go to HALT; otherwise stay.
REQ-018 HALT: G_cs=0, O_halt=1; next state SHALL be ALIGN if I_odd=1, else READ.
REQ-019 ALIGN: G_cs=0, O_halt=1; the next state SHALL be READ.
REQ-020 READ: G_cs=1, O_rdwr=1, O_addr={page,index}, O_halt=1; the next state SHALL be WRITE.
REQ-021 WRITE: G_cs=1, O_rdwr=0, O_addr=P_dest, O_wr_data=I_rd_data (combinational, captures the byte read in the preceding READ), O_halt=1.
REQ-022 WRITE: if index==P_count-1 the next state SHALL be DONE, else index+1 and READ.
REQ-023 Index SHALL be 8 bits; source address SHALL never carry into the page byte.
REQ-024 DONE: O_done=1, O_halt=0, G_cs=0, O_busy=1 for exactly one cycle; the next state SHALL be IDLE.
REQ-025 I_start SHALL be ignored in all states except IDLE, including DONE.
REQ-026 Outside WRITE, O_wr_data SHALL be 8'h00; outside READ/WRITE, O_addr SHALL be 16'h0000 and O_rdwr SHALL be 1.
REQ-027 O_halt SHALL be high for exactly 1+A+2*P_count cycles per transfer, where A=I_odd sampled in HALT (513/514 at default).
REQ-028 All outputs except O_wr_data SHALL be registered or decoded from the state register only.

Reset
REQ-029 I_reset_n=0 SHALL immediately force IDLE, index=0, page=0, and outputs: O_busy=0, O_halt=0, O_done=0, G_cs=0, O_rdwr=1, O_addr=0, O_wr_data=0.
REQ-030 Reset mid-transfer SHALL abandon the transfer with no O_done pulse; the next accepted start SHALL begin at index 0.

Verification
REQ-031 Reset assert/release with I_start=0 -> all outputs hold REQ-029 values; no G_cs for 20 cycles.
REQ-032 Memory 0x0200..0x02FF=i^8'h5A, I_page=8'h02, I_odd=0 -> O_halt high 513 cycles; reads at 0x0200..0x02FF alternate with writes at 0x2004 carrying 0x5A,0x5B,...; one O_done pulse.
REQ-033 Same with I_odd=1 -> O_halt high 514 cycles; first READ occurs 2 cycles after HALT; data sequence identical.
REQ-034 I_start pulsed during READ at index 10 and during DONE -> ignored; exactly one transfer, O_busy drops one cycle after O_done.
REQ-035 I_reset_n low at index 100 during WRITE -> G_cs=0 and O_halt=0 in the same cycle; no O_done; a new start at page 8'h03 reads 0x0300 first.
REQ-036 P_count=4, I_page=8'hAB, I_odd=0 -> reads 0xAB00..0xAB03, O_halt high 9 cycles, O_done once.
